// File: rtl/mem_arbiter.sv
// Round-robin arbiter that multiplexes the I-side and D-side L1 wishbone miss ports onto one downstream master.
// Only one side is granted at a time, and an idle cycle always separates two transactions.
module mem_arbiter #(
  parameter int ADR_W = 12,
  parameter int DAT_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cyc,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic [ADR_W-1:0] i_adr,
  input  logic [15:0]      i_sel,
  input  logic [DAT_W-1:0] i_dat_m,
  output logic [DAT_W-1:0] i_dat_s,
  output logic             i_ack,
  output logic             i_rty,
  input  logic             d_cyc,
  input  logic             d_stb,
  input  logic             d_we,
  input  logic [ADR_W-1:0] d_adr,
  input  logic [15:0]      d_sel,
  input  logic [DAT_W-1:0] d_dat_m,
  output logic [DAT_W-1:0] d_dat_s,
  output logic             d_ack,
  output logic             d_rty,
  output logic             m_cyc,
  output logic             m_stb,
  output logic             m_we,
  output logic [ADR_W-1:0] m_adr,
  output logic [15:0]      m_sel,
  output logic [DAT_W-1:0] m_dat_m,
  input  logic [DAT_W-1:0] m_dat_s,
  input  logic             m_ack,
  input  logic             m_rty,
  output logic [15:0]      grant_i_cnt,
  output logic [15:0]      grant_d_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  state_t      state_q, state_d;
  logic        lastGnt_q, lastGnt_d;
  logic [15:0] cntI_q, cntI_d;
  logic [15:0] cntD_q, cntD_d;
  logic        iReq, dReq;

  assign iReq = i_cyc & i_stb;
  assign dReq = d_cyc & d_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lastGnt_q <= SIDE_I;
      cntI_q    <= 16'd0;
      cntD_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      lastGnt_q <= lastGnt_d;
      cntI_q    <= cntI_d;
      cntD_q    <= cntD_d;
    end
  end

  // Dropping cyc takes priority over a coincident ack, so an aborted cycle is never counted.
  always_comb begin
    state_d   = state_q;
    lastGnt_d = lastGnt_q;
    cntI_d    = cntI_q;
    cntD_d    = cntD_q;
    case (state_q)
      IDLE: begin
        if (iReq && dReq) state_d = (lastGnt_q == SIDE_I) ? GNT_D : GNT_I;
        else if (iReq)    state_d = GNT_I;
        else if (dReq)    state_d = GNT_D;
      end
      GNT_I: begin
        if (!i_cyc) begin
          state_d = IDLE;
        end else if (m_ack) begin
          state_d   = IDLE;
          lastGnt_d = SIDE_I;
          cntI_d    = cntI_q + 16'd1;
        end
      end
      GNT_D: begin
        if (!d_cyc) begin
          state_d = IDLE;
        end else if (m_ack) begin
          state_d   = IDLE;
          lastGnt_d = SIDE_D;
          cntD_d    = cntD_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The losing or waiting side always sees retry, so it keeps its request up until it is granted.
  always_comb begin
    m_cyc   = 1'b0;
    m_stb   = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_sel   = '0;
    m_dat_m = '0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    i_rty   = iReq;
    d_rty   = dReq;
    case (state_q)
      GNT_I: begin
        m_cyc   = i_cyc;
        m_stb   = i_stb;
        m_we    = i_we;
        m_adr   = i_adr;
        m_sel   = i_sel;
        m_dat_m = i_dat_m;
        i_ack   = m_ack;
        i_rty   = m_rty;
      end
      GNT_D: begin
        m_cyc   = d_cyc;
        m_stb   = d_stb;
        m_we    = d_we;
        m_adr   = d_adr;
        m_sel   = d_sel;
        m_dat_m = d_dat_m;
        d_ack   = m_ack;
        d_rty   = m_rty;
      end
      default: ;
    endcase
  end

  assign i_dat_s     = m_dat_s;
  assign d_dat_s     = m_dat_s;
  assign grant_i_cnt = cntI_q;
  assign grant_d_cnt = cntD_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: randomized transactions compared against a
// transaction-level round-robin model kept here.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rstN;
  logic         iCyc, iStb, iWe;
  logic [11:0]  iAdr;
  logic [15:0]  iSel;
  logic [127:0] iDatM, iDatS;
  logic         iAck, iRty;
  logic         dCyc, dStb, dWe;
  logic [11:0]  dAdr;
  logic [15:0]  dSel;
  logic [127:0] dDatM, dDatS;
  logic         dAck, dRty;
  logic         mCyc, mStb, mWe;
  logic [11:0]  mAdr;
  logic [15:0]  mSel;
  logic [127:0] mDatM, mDatS;
  logic         mAck, mRty;
  logic [15:0]  grantICnt, grantDCnt;

  int checks = 0;
  int fails = 0;
  logic [15:0] expCntI, expCntD;
  bit expLastD;

  mem_arbiter dut (
    .clk(clk), .rst_n(rstN),
    .i_cyc(iCyc), .i_stb(iStb), .i_we(iWe), .i_adr(iAdr), .i_sel(iSel), .i_dat_m(iDatM),
    .i_dat_s(iDatS), .i_ack(iAck), .i_rty(iRty),
    .d_cyc(dCyc), .d_stb(dStb), .d_we(dWe), .d_adr(dAdr), .d_sel(dSel), .d_dat_m(dDatM),
    .d_dat_s(dDatS), .d_ack(dAck), .d_rty(dRty),
    .m_cyc(mCyc), .m_stb(mStb), .m_we(mWe), .m_adr(mAdr), .m_sel(mSel), .m_dat_m(mDatM),
    .m_dat_s(mDatS), .m_ack(mAck), .m_rty(mRty),
    .grant_i_cnt(grantICnt), .grant_d_cnt(grantDCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Round-robin rule: a conflict goes to the side that did not finish last.
  function automatic bit pickD(input bit iR, input bit dR, input bit lastD);
    if (iR && dR) return !lastD;
    return dR;
  endfunction

  task automatic idleInputs();
    iCyc = 0; iStb = 0; iWe = 0; iAdr = '0; iSel = '0; iDatM = '0;
    dCyc = 0; dStb = 0; dWe = 0; dAdr = '0; dSel = '0; dDatM = '0;
    mAck = 0; mRty = 0; mDatS = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idleInputs();
    rstN = 1'b0;
    iCyc = 1; iStb = 1;
    @(negedge clk);
    checks++; if (mCyc !== 1'b0) begin fails++; $display("[TB] FAIL reset_mcyc: got %b expected 0", mCyc); end
    checks++; if (grantICnt !== 16'd0 || grantDCnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_cnt: got I=%0h D=%0h expected 0/0", grantICnt, grantDCnt); end
    checks++; if (iAck !== 1'b0 || dAck !== 1'b0) begin fails++; $display("[TB] FAIL reset_ack: got i=%b d=%b expected 0/0", iAck, dAck); end
    checks++; if (iRty !== 1'b1 || dRty !== 1'b0) begin fails++; $display("[TB] FAIL reset_rty: got i=%b d=%b expected 1/0", iRty, dRty); end
    iCyc = 0; iStb = 0;
    expCntI = 0; expCntD = 0; expLastD = 0;
    @(negedge clk);
    rstN = 1'b1;
    nextCycle();
  endtask

  task automatic test_round_robin(input int nTxn);
    bit wD;
    int lat;
    logic [127:0] rd;
    iCyc = 1; iStb = 1; iWe = 0; iAdr = 12'($urandom); iSel = 16'($urandom); iDatM = rand128();
    dCyc = 1; dStb = 1; dWe = 1'($urandom); dAdr = 12'($urandom); dSel = 16'($urandom); dDatM = rand128();
    @(negedge clk);
    checks++; if (mCyc !== 1'b0 || iRty !== 1'b1 || dRty !== 1'b1) begin fails++; $display("[TB] FAIL rr_idle: got mcyc=%b irty=%b drty=%b expected 0/1/1", mCyc, iRty, dRty); end
    for (int t = 0; t < nTxn; t++) begin
      wD = pickD(1'b1, 1'b1, expLastD);
      nextCycle();
      lat = $urandom_range(0, 2);
      for (int k = 0; k <= lat; k++) begin
        if (k == lat) begin mAck = 1; rd = rand128(); mDatS = rd; end
        @(negedge clk);
        checks++; if (mCyc !== 1'b1 || mAdr !== (wD ? dAdr : iAdr)) begin fails++; $display("[TB] FAIL rr_grant t=%0d: got cyc=%b adr=%h expected 1 %h (D=%0d)", t, mCyc, mAdr, wD ? dAdr : iAdr, wD); end
        checks++; if ((wD ? iRty : dRty) !== 1'b1 || (wD ? iAck : dAck) !== 1'b0) begin fails++; $display("[TB] FAIL rr_loser t=%0d: got rty=%b ack=%b expected 1/0", t, wD ? iRty : dRty, wD ? iAck : dAck); end
        checks++; if ((wD ? dAck : iAck) !== (k == lat)) begin fails++; $display("[TB] FAIL rr_ack t=%0d: got %b expected %b", t, wD ? dAck : iAck, k == lat); end
        if (k < lat) nextCycle();
      end
      checks++; if ((wD ? dDatS : iDatS) !== rd) begin fails++; $display("[TB] FAIL rr_rdata t=%0d: got %h expected %h", t, wD ? dDatS : iDatS, rd); end
      nextCycle();
      mAck = 0;
      if (wD) expCntD++; else expCntI++;
      expLastD = wD;
      @(negedge clk);
      checks++; if (mCyc !== 1'b0 || grantICnt !== expCntI || grantDCnt !== expCntD) begin fails++; $display("[TB] FAIL rr_gap t=%0d: got cyc=%b I=%0d D=%0d expected 0 %0d %0d", t, mCyc, grantICnt, grantDCnt, expCntI, expCntD); end
      iAdr = 12'($urandom); dAdr = 12'($urandom);
    end
    iCyc = 0; iStb = 0; dCyc = 0; dStb = 0;
    nextCycle();
  endtask

  task automatic test_i_read();
    logic [127:0] rd;
    iCyc = 1; iStb = 1; iWe = 0; iAdr = 12'h123; iSel = 16'($urandom); iDatM = rand128();
    @(negedge clk);
    checks++; if (mCyc !== 1'b0) begin fails++; $display("[TB] FAIL iread_latency: got %b expected 0", mCyc); end
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      if (c == 3) begin mAck = 1; rd = rand128(); mDatS = rd; end
      @(negedge clk);
      checks++; if (mCyc !== 1'b1 || mStb !== 1'b1 || mAdr !== 12'h123 || mSel !== iSel) begin fails++; $display("[TB] FAIL iread_fwd c=%0d: got cyc=%b adr=%h sel=%h expected 1 123 %h", c, mCyc, mAdr, mSel, iSel); end
      checks++; if (iAck !== (c == 3) || dAck !== 1'b0) begin fails++; $display("[TB] FAIL iread_ack c=%0d: got i=%b d=%b expected %b/0", c, iAck, dAck, c == 3); end
    end
    checks++; if (iDatS !== rd) begin fails++; $display("[TB] FAIL iread_data: got %h expected %h", iDatS, rd); end
    nextCycle();
    mAck = 0; iCyc = 0; iStb = 0;
    expCntI++; expLastD = 0;
    @(negedge clk);
    checks++; if (mCyc !== 1'b0 || grantICnt !== expCntI || dAck !== 1'b0) begin fails++; $display("[TB] FAIL iread_done: got cyc=%b I=%0d dack=%b expected 0 %0d 0", mCyc, grantICnt, dAck, expCntI); end
    nextCycle();
  endtask

  task automatic test_retry();
    dCyc = 1; dStb = 1; dWe = 1; dAdr = 12'($urandom); dSel = 16'($urandom); dDatM = rand128();
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin mRty = 1; mAck = 0; end
      else begin mRty = 0; mAck = 1; end
      @(negedge clk);
      checks++; if (mCyc !== 1'b1 || mWe !== 1'b1 || mDatM !== dDatM) begin fails++; $display("[TB] FAIL retry_fwd k=%0d: got cyc=%b we=%b dat=%h expected 1 1 %h", k, mCyc, mWe, mDatM, dDatM); end
      checks++; if (dRty !== (k < 2) || dAck !== (k == 2)) begin fails++; $display("[TB] FAIL retry_hs k=%0d: got rty=%b ack=%b expected %b/%b", k, dRty, dAck, k < 2, k == 2); end
      nextCycle();
    end
    mAck = 0; dCyc = 0; dStb = 0; dWe = 0;
    expCntD++; expLastD = 1;
    @(negedge clk);
    checks++; if (mCyc !== 1'b0 || grantDCnt !== expCntD || grantICnt !== expCntI) begin fails++; $display("[TB] FAIL retry_cnt: got cyc=%b I=%0d D=%0d expected 0 %0d %0d", mCyc, grantICnt, grantDCnt, expCntI, expCntD); end
    nextCycle();
  endtask

  task automatic test_abort();
    iCyc = 1; iStb = 1; iAdr = 12'($urandom);
    dAdr = 12'($urandom);
    nextCycle();
    dCyc = 1; dStb = 1;
    @(negedge clk);
    checks++; if (mCyc !== 1'b1 || mAdr !== iAdr || dRty !== 1'b1 || dAck !== 1'b0) begin fails++; $display("[TB] FAIL abort_grant: got cyc=%b adr=%h drty=%b dack=%b expected 1 %h 1 0", mCyc, mAdr, dRty, dAck, iAdr); end
    nextCycle();
    iCyc = 0;
    @(negedge clk);
    checks++; if (mCyc !== 1'b0) begin fails++; $display("[TB] FAIL abort_drop: got %b expected 0", mCyc); end
    nextCycle();
    iStb = 0;
    @(negedge clk);
    checks++; if (mCyc !== 1'b0 || grantICnt !== expCntI || dRty !== 1'b1) begin fails++; $display("[TB] FAIL abort_idle: got cyc=%b I=%0d drty=%b expected 0 %0d 1", mCyc, grantICnt, dRty, expCntI); end
    nextCycle();
    @(negedge clk);
    checks++; if (mCyc !== 1'b1 || mAdr !== dAdr) begin fails++; $display("[TB] FAIL abort_next: got cyc=%b adr=%h expected 1 %h", mCyc, mAdr, dAdr); end
    mAck = 1;
    #1;
    checks++; if (dAck !== 1'b1 || iAck !== 1'b0) begin fails++; $display("[TB] FAIL abort_dack: got d=%b i=%b expected 1/0", dAck, iAck); end
    nextCycle();
    mAck = 0; dCyc = 0; dStb = 0;
    expCntD++; expLastD = 1;
    @(negedge clk);
    checks++; if (grantDCnt !== expCntD || grantICnt !== expCntI) begin fails++; $display("[TB] FAIL abort_cnt: got I=%0d D=%0d expected %0d %0d", grantICnt, grantDCnt, expCntI, expCntD); end
    nextCycle();
  endtask

  task automatic test_idle_ack();
    logic [127:0] rd;
    rd = rand128();
    mAck = 1; mDatS = rd;
    @(negedge clk);
    checks++; if (iAck !== 1'b0 || dAck !== 1'b0) begin fails++; $display("[TB] FAIL idleack_fwd: got i=%b d=%b expected 0/0", iAck, dAck); end
    checks++; if (iDatS !== rd || dDatS !== rd) begin fails++; $display("[TB] FAIL idleack_data: got i=%h d=%h expected %h", iDatS, dDatS, rd); end
    nextCycle();
    mAck = 0;
    @(negedge clk);
    checks++; if (mCyc !== 1'b0 || grantICnt !== expCntI || grantDCnt !== expCntD) begin fails++; $display("[TB] FAIL idleack_state: got cyc=%b I=%0d D=%0d expected 0 %0d %0d", mCyc, grantICnt, grantDCnt, expCntI, expCntD); end
    nextCycle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] wrapExp;
    dCyc = 1; dStb = 1; dAdr = 12'($urandom);
    nextCycle();
    @(negedge clk);
    checks++; if (mCyc !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_grant: got %b expected 1", mCyc); end
    rstN = 0; mAck = 1;
    expCntI = 0; expCntD = 0; expLastD = 0;
    #1;
    checks++; if (mCyc !== 1'b0 || dAck !== 1'b0 || dRty !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_async: got cyc=%b ack=%b rty=%b expected 0 0 1", mCyc, dAck, dRty); end
    checks++; if (grantICnt !== expCntI || grantDCnt !== expCntD) begin fails++; $display("[TB] FAIL rstmid_cnt: got I=%0d D=%0d expected 0/0", grantICnt, grantDCnt); end
    mAck = 0;
    @(negedge clk);
    rstN = 1;
    nextCycle();
    @(negedge clk);
    checks++; if (mCyc !== 1'b1 || mAdr !== dAdr) begin fails++; $display("[TB] FAIL rstmid_restart: got cyc=%b adr=%h expected 1 %h", mCyc, mAdr, dAdr); end
    force dut.cntD_q = 16'hFFFF;
    #1;
    release dut.cntD_q;
    #1;
    checks++; if (grantDCnt !== 16'hFFFF) begin fails++; $display("[TB] FAIL wrap_preload: got %h expected ffff", grantDCnt); end
    mAck = 1;
    nextCycle();
    mAck = 0; dCyc = 0; dStb = 0;
    wrapExp = 16'hFFFF;
    wrapExp = wrapExp + 16'd1;
    @(negedge clk);
    checks++; if (grantDCnt !== wrapExp || grantICnt !== 16'd0) begin fails++; $display("[TB] FAIL wrap_cnt: got D=%h I=%h expected %h 0000", grantDCnt, grantICnt, wrapExp); end
    nextCycle();
  endtask

  initial begin
    test_reset();
    test_round_robin(2);
    test_i_read();
    test_retry();
    test_abort();
    test_idle_ack();
    test_reset();
    test_round_robin(8);
    checks++; if (grantICnt !== 16'd4 || grantDCnt !== 16'd4) begin fails++; $display("[TB] FAIL rr_eight: got I=%0d D=%0d expected 4/4", grantICnt, grantDCnt); end
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADR_W, default 12, line-address width (16-bit byte address, bits [15:4]).
REQ-002 Parameter DAT_W, default 128, line data width (8 words).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 i_cyc, i_stb, i_we  in  1 each  wishbone master controls from the I-side L1 miss port.
REQ-006 i_adr  in  ADR_W; i_sel  in  16; i_dat_m  in  DAT_W  I-side address, byte select and write data.
REQ-007 i_dat_s  out  DAT_W; i_ack, i_rty  out  1 each  I-side read data and handshake returns.
REQ-008 d_cyc, d_stb, d_we, d_adr, d_sel, d_dat_m (in) and d_dat_s, d_ack, d_rty (out)  same widths  D-side L1 miss/writeback port.
REQ-009 m_cyc, m_stb, m_we  out  1; m_adr  out  ADR_W; m_sel  out  16; m_dat_m  out  DAT_W  downstream master to memory/L2.
REQ-010 m_dat_s  in  DAT_W; m_ack, m_rty  in  1  downstream returns.
REQ-011 grant_i_cnt, grant_d_cnt  out  16 each  completed-transaction counters per side.

Function
REQ-012 FSM states: IDLE, GNT_I, GNT_D; state register is the only source of grant.
REQ-013 Request on a side = cyc & stb of that side.
REQ-014 IDLE, one request -> grant that side next cycle; no request -> stay IDLE.
REQ-015 IDLE, both request -> grant side opposite to last_gnt flag (round-robin); last_gnt resets to I, so D wins first conflict.
REQ-016 Grant latency: request first seen in IDLE at edge n -> m_cyc/m_stb high from cycle n+1.
REQ-017 In GNT_x: m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m combinationally equal the granted side's inputs; in IDLE all m_* outputs 0.
REQ-018 m_dat_s driven to both i_dat_s and d_dat_s unconditionally; only ack/rty qualify it.
REQ-019 Granted side: x_ack = m_ack, x_rty = m_rty, same cycle, no registering.
REQ-020 Non-granted side: x_ack = 0 always; x_rty = x_cyc & x_stb (stall retry) while the other side holds grant or while in IDLE.
REQ-021 GNT_x with m_ack=1 -> IDLE next cycle, last_gnt <= x, grant_x_cnt increments by 1.
REQ-022 One dead IDLE cycle between back-to-back transactions is required; no grant hand-off directly GNT_I<->GNT_D.
REQ-023 GNT_x with m_rty=1 and no ack -> stay in GNT_x; the requester repeats, grant held.
REQ-024 Abort: granted side drops cyc before m_ack -> IDLE next cycle, m_* follow the dropped inputs that cycle, no counter increment, last_gnt unchanged.
REQ-025 m_ack asserted while in IDLE is ignored (no ack forwarded, no state change).
REQ-026 Counters 16-bit, wrap 0xFFFF -> 0x0000, no saturation.
REQ-027 Grant never changes while m_cyc is high except via REQ-021/REQ-024.

Reset
REQ-028 rst_n low: state=IDLE, last_gnt=I, both counters 0, all m_* and x_ack low immediately (async), x_rty follows REQ-020.
REQ-029 Reset asserted mid-transaction abandons it; no partial ack is forwarded; after rst_n rises, arbitration restarts from IDLE on the next edge.

Verification
REQ-030 I-side read alone: i_cyc=i_stb=1, i_adr=0x123, memory acks 3 cycles later -> m_adr=0x123 from cycle 1, i_ack pulses with m_ack, grant_i_cnt=1, d_ack never high.
REQ-031 Simultaneous requests after reset: D granted first, i_rty=1 throughout; after D ack and one IDLE cycle I granted; counters I=1, D=1.
REQ-032 Continuous dual requests for 8 transactions -> grants alternate D,I,D,I,...; each counter=4.
REQ-033 D write with m_rty for 2 cycles then ack -> state held GNT_D, d_rty mirrors m_rty, m_we=1, m_dat_m=d_dat_m; one increment only.
REQ-034 I granted, i_cyc dropped before ack -> m_cyc low same cycle, IDLE next, grant_i_cnt unchanged; pending D then granted.
REQ-035 rst_n pulsed low during GNT_D -> m_cyc low asynchronously, counters 0; preload grant_d_cnt to 0xFFFF by stimulus, one more D ack -> 0x0000.
